// File: rtl/gpu_pkg.sv
// gpu_pkg: shared parameters, opcode encoding, instruction field positions
// and the vector type used by the gpu_core SIMD vector core.
package gpu_pkg;

  localparam int NUM_LANES  = 16;
  localparam int NUM_VREGS  = 8;
  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 64;
  localparam int DMEM_DEPTH = 64;

  localparam int VREG_AW = 3;
  localparam int IMEM_AW = 6;
  localparam int DMEM_AW = 6;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  // Instruction field bit positions
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int DST_MSB  = 25;
  localparam int DST_LSB  = 23;
  localparam int SRC1_MSB = 22;
  localparam int SRC1_LSB = 20;
  localparam int SRC2_MSB = 19;
  localparam int SRC2_LSB = 17;
  localparam int RSVD_BIT = 16;
  localparam int MASK_MSB = 15;
  localparam int MASK_LSB = 0;

  typedef enum logic [5:0] {
    OP_NOP    = 6'b000000,
    OP_VADD   = 6'b000001,
    OP_VSUB   = 6'b000010,
    OP_VAND   = 6'b000011,
    OP_VOR    = 6'b000100,
    OP_VXOR   = 6'b000101,
    OP_VLOAD  = 6'b100000,
    OP_VSTORE = 6'b100001
  } opcode_e;

  typedef logic [NUM_LANES-1:0][DATA_W-1:0] vec_t;
  typedef logic [NUM_LANES-1:0]             mask_t;

  // A lane mask that only takes effect when its enable is set.
  function automatic mask_t gate_mask(input logic en, input mask_t m);
    mask_t r;
    if (en) begin
      r = m;
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_dmem.sv
// gpu_dmem: vector-wide data memory, DMEM_DEPTH x NUM_LANES x DATA_W.
// Ports: i_clk; i_addr shared by the combinational read (o_rdata) and
//        the lane-masked write (i_we/i_wmask/i_wdata). Not reset.
module gpu_dmem
  import gpu_pkg::*;
(
  input  logic               i_clk,
  input  logic [DMEM_AW-1:0] i_addr,
  input  logic               i_we,
  input  mask_t              i_wmask,
  input  vec_t               i_wdata,
  output vec_t               o_rdata
);

  logic [DATA_W-1:0] memory [DMEM_DEPTH][NUM_LANES];

  // Per-lane masked memory write
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (i_wmask[l]) begin
          memory[i_addr][l] <= i_wdata[l];
        end
      end
    end
  end

  // Combinational vector read
  always_comb begin
    o_rdata = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      o_rdata[l] = memory[i_addr][l];
    end
  end

endmodule

// File: rtl/gpu_imem.sv
// gpu_imem: instruction memory, IMEM_DEPTH x 32 bits.
// Ports: i_clk, i_we/i_waddr/i_wdata (program load port),
//        i_raddr (word index) -> o_rdata (combinational fetch).
// Contents are normally preloaded from outside; nothing clears them.
module gpu_imem
  import gpu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [IMEM_AW-1:0] i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [IMEM_AW-1:0] i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] memory [IMEM_DEPTH];

  // Optional program load write
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      memory[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = memory[i_raddr];

endmodule

// File: rtl/gpu_vrf.sv
// gpu_vrf: vector register file, NUM_VREGS x NUM_LANES x DATA_W.
// Ports: i_clk; masked write port i_we/i_wmask/i_waddr/i_wdata;
//        three combinational read ports i_raddr1/2/d -> o_rdata1/2/d.
// Registers are not reset.
module gpu_vrf
  import gpu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  mask_t              i_wmask,
  input  logic [VREG_AW-1:0] i_waddr,
  input  vec_t               i_wdata,
  input  logic [VREG_AW-1:0] i_raddr1,
  input  logic [VREG_AW-1:0] i_raddr2,
  input  logic [VREG_AW-1:0] i_raddrd,
  output vec_t               o_rdata1,
  output vec_t               o_rdata2,
  output vec_t               o_rdatad
);

  logic [DATA_W-1:0] M_V_Regs [NUM_VREGS][NUM_LANES];

  // Per-lane masked register write
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (i_wmask[l]) begin
          M_V_Regs[i_waddr][l] <= i_wdata[l];
        end
      end
    end
  end

  // Combinational read ports
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    o_rdatad = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      o_rdata1[l] = M_V_Regs[i_raddr1][l];
      o_rdata2[l] = M_V_Regs[i_raddr2][l];
      o_rdatad[l] = M_V_Regs[i_raddrd][l];
    end
  end

endmodule

// File: rtl/gpu_core.sv
// gpu_core: single-issue, single-cycle 16-lane SIMD vector core.
// Ports: clk (rising edge), rst_n (asynchronous, ACTIVE-HIGH despite its
//        name; only the PC is cleared). No data ports: program and data
//        live in imem_inst, vrf_inst and dmem_inst.
module gpu_core
  import gpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] w_instr;
  opcode_e            w_op;
  logic [VREG_AW-1:0] w_dst;
  logic [VREG_AW-1:0] w_src1;
  logic [VREG_AW-1:0] w_src2;
  mask_t              w_mask;
  logic               w_unused_rsvd;

  vec_t               w_rd1;
  vec_t               w_rd2;
  vec_t               w_rdd;
  vec_t               w_dmem_rdata;
  vec_t               w_vrf_wdata;
  logic               w_vrf_wr;
  logic               w_dmem_wr;
  logic               w_vrf_we;
  logic               w_dmem_we;
  logic [DMEM_AW-1:0] w_addr;

  // Byte PC: cleared asynchronously, otherwise +4 per clock (wraps at 256)
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pc <= 8'd0;
    end else begin
      r_pc <= r_pc + 8'd4;
    end
  end

  gpu_imem imem_inst (
    .i_clk   (clk),
    .i_we    (1'b0),
    .i_waddr ({IMEM_AW{1'b0}}),
    .i_wdata ({INSTR_W{1'b0}}),
    .i_raddr (r_pc[PC_W-1:2]),
    .o_rdata (w_instr)
  );

  assign w_op          = opcode_e'(w_instr[OPC_MSB:OPC_LSB]);
  assign w_dst         = w_instr[DST_MSB:DST_LSB];
  assign w_src1        = w_instr[SRC1_MSB:SRC1_LSB];
  assign w_src2        = w_instr[SRC2_MSB:SRC2_LSB];
  assign w_mask        = w_instr[MASK_MSB:MASK_LSB];
  assign w_unused_rsvd = w_instr[RSVD_BIT];

  // Memory address comes from the low bits of src1 lane 0 only
  assign w_addr = w_rd1[0][DMEM_AW-1:0];

  // Lane ALU and write-enable decode; unknown opcodes fall through as NOP
  always_comb begin
    w_vrf_wdata = '0;
    w_vrf_wr    = 1'b0;
    w_dmem_wr   = 1'b0;
    case (w_op)
      OP_VADD: begin
        w_vrf_wr = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) w_vrf_wdata[l] = w_rd1[l] + w_rd2[l];
      end
      OP_VSUB: begin
        w_vrf_wr = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) w_vrf_wdata[l] = w_rd1[l] - w_rd2[l];
      end
      OP_VAND: begin
        w_vrf_wr = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) w_vrf_wdata[l] = w_rd1[l] & w_rd2[l];
      end
      OP_VOR: begin
        w_vrf_wr = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) w_vrf_wdata[l] = w_rd1[l] | w_rd2[l];
      end
      OP_VXOR: begin
        w_vrf_wr = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) w_vrf_wdata[l] = w_rd1[l] ^ w_rd2[l];
      end
      OP_VLOAD: begin
        w_vrf_wr    = 1'b1;
        w_vrf_wdata = w_dmem_rdata;
      end
      OP_VSTORE: begin
        w_dmem_wr = 1'b1;
      end
      default: begin
        w_vrf_wr  = 1'b0;
        w_dmem_wr = 1'b0;
      end
    endcase
  end

  // No architectural writes while reset is held, including the in-flight op
  assign w_vrf_we  = w_vrf_wr  & ~rst_n;
  assign w_dmem_we = w_dmem_wr & ~rst_n;

  gpu_vrf vrf_inst (
    .i_clk    (clk),
    .i_we     (w_vrf_we),
    .i_wmask  (gate_mask(w_vrf_we, w_mask)),
    .i_waddr  (w_dst),
    .i_wdata  (w_vrf_wdata),
    .i_raddr1 (w_src1),
    .i_raddr2 (w_src2),
    .i_raddrd (w_dst),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .o_rdatad (w_rdd)
  );

  gpu_dmem dmem_inst (
    .i_clk   (clk),
    .i_addr  (w_addr),
    .i_we    (w_dmem_we),
    .i_wmask (gate_mask(w_dmem_we, w_mask)),
    .i_wdata (w_rdd),
    .o_rdata (w_dmem_rdata)
  );

endmodule

// File: tb/tb_gpu_core.sv
// tb_gpu_core: self-checking bench for gpu_core. Each scenario preloads
// program/data hierarchically, pushes expected state onto a scoreboard
// queue, runs the core and pops/compares against the DUT storage.
module tb_gpu_core;
  import gpu_pkg::*;

  logic clk;
  logic rst_n;

  gpu_core dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_V  = 0;
  localparam int K_D  = 1;
  localparam int K_PC = 2;

  typedef struct {
    int          kind;
    int          idx;
    int          lane;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] d,
                                      input logic [2:0] s1, input logic [2:0] s2,
                                      input logic [15:0] m);
    return {op, d, s1, s2, 1'b0, m};
  endfunction

  function automatic logic [31:0] vinit(input int r, input int l);
    return 32'hDEAD_0000 + 32'(r * 256 + l);
  endfunction

  function automatic logic [31:0] dinit(input int a, input int l);
    return 32'hD000_0000 + 32'(a * 256 + l);
  endfunction

  function automatic logic [31:0] obs(input int kind, input int idx, input int lane);
    logic [31:0] r;
    case (kind)
      K_V:     r = dut.vrf_inst.M_V_Regs[idx][lane];
      K_D:     r = dut.dmem_inst.memory[idx][lane];
      default: r = {24'd0, dut.r_pc};
    endcase
    return r;
  endfunction

  task automatic push(input int kind, input int idx, input int lane, input logic [31:0] val);
    exp_t e;
    e.kind = kind; e.idx = idx; e.lane = lane; e.val = val;
    sb.push_back(e);
  endtask

  // Enter reset and load known background into all storage
  task automatic setup();
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < IMEM_DEPTH; k++) dut.imem_inst.memory[k] = 32'd0;
    for (int r = 0; r < NUM_VREGS; r++)
      for (int l = 0; l < NUM_LANES; l++) dut.vrf_inst.M_V_Regs[r][l] = vinit(r, l);
    for (int a = 0; a < DMEM_DEPTH; a++)
      for (int l = 0; l < NUM_LANES; l++) dut.dmem_inst.memory[a][l] = dinit(a, l);
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    setup();
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VSTORE, 3'd0, 3'd3, 3'd0, 16'hFFFF);
    push(K_PC, 0, 0, 32'd0);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, vinit(0, l));
      push(K_V, 1, l, vinit(1, l));
      push(K_D, 0, l, dinit(0, l));
    end
    repeat (5) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL reset k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      dut.vrf_inst.M_V_Regs[1][l] = 32'(l + 1);
      dut.vrf_inst.M_V_Regs[2][l] = 32'(100 + l);
      dut.vrf_inst.M_V_Regs[3][l] = 32'd5;
    end
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VSTORE, 3'd0, 3'd3, 3'd0, 16'hFFFF);
    dut.imem_inst.memory[2] = enc(OP_VLOAD, 3'd4, 3'd3, 3'd0, 16'hFFFF);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, 32'(101 + 2 * l));
      push(K_D, 5, l, 32'(101 + 2 * l));
      push(K_V, 4, l, 32'(101 + 2 * l));
    end
    push(K_PC, 0, 0, 32'd40);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL basic k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_mask();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      dut.vrf_inst.M_V_Regs[0][l] = 32'd7;
      dut.vrf_inst.M_V_Regs[1][l] = 32'(l + 1);
      dut.vrf_inst.M_V_Regs[2][l] = 32'(100 + l);
      dut.vrf_inst.M_V_Regs[3][l] = 32'd5;
    end
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd0, 3'd1, 3'd2, 16'h00FF);
    dut.imem_inst.memory[1] = enc(OP_VSTORE, 3'd0, 3'd3, 3'd0, 16'h8001);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, (l < 8) ? 32'(101 + 2 * l) : 32'd7);
      if (l == 0)       push(K_D, 5, l, 32'd101);
      else if (l == 15) push(K_D, 5, l, 32'd7);
      else              push(K_D, 5, l, dinit(5, l));
    end
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL mask k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      dut.vrf_inst.M_V_Regs[1][l] = 32'hFFFF_FFFF;
      dut.vrf_inst.M_V_Regs[2][l] = 32'd1;
      dut.vrf_inst.M_V_Regs[3][l] = (l == 0) ? 32'h0000_0045 : 32'd9;
    end
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VSTORE, 3'd0, 3'd3, 3'd0, 16'hFFFF);
    dut.imem_inst.memory[2] = enc(OP_VSUB, 3'd5, 3'd2, 3'd1, 16'hFFFF);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, 32'd0);
      push(K_D, 5, l, 32'd0);
      push(K_D, 9, l, dinit(9, l));
      push(K_V, 5, l, 32'd2);
    end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL wrap k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_logic();
    exp_t e; logic [31:0] got;
    logic [31:0] a [NUM_LANES];
    logic [31:0] b [NUM_LANES];
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      a[l] = $urandom; b[l] = $urandom;
      dut.vrf_inst.M_V_Regs[1][l] = a[l];
      dut.vrf_inst.M_V_Regs[2][l] = b[l];
      dut.vrf_inst.M_V_Regs[3][l] = (l == 0) ? 32'hFFFF_FFE1 : 32'd2;
    end
    dut.imem_inst.memory[0] = enc(OP_VSUB, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VAND, 3'd4, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[2] = enc(OP_VOR, 3'd5, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[3] = enc(OP_VXOR, 3'd6, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[4] = enc(OP_VLOAD, 3'd7, 3'd3, 3'd0, 16'h0F0F);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, a[l] - b[l]);
      push(K_V, 4, l, a[l] & b[l]);
      push(K_V, 5, l, a[l] | b[l]);
      push(K_V, 6, l, a[l] ^ b[l]);
      push(K_V, 7, l, (((l / 4) % 2) == 0) ? dinit(33, l) : vinit(7, l));
    end
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL logic k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      dut.vrf_inst.M_V_Regs[1][l] = 32'(l + 1);
      dut.vrf_inst.M_V_Regs[2][l] = 32'(100 + l);
    end
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd0, 3'd1, 3'd2, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VADD, 3'd5, 3'd0, 3'd1, 16'hFFFF);
    dut.imem_inst.memory[2] = enc(OP_VADD, 3'd6, 3'd0, 3'd0, 16'hFFFF);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(K_PC, 0, 0, 32'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL midrst_pc k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, 32'(101 + 2 * l));
      push(K_V, 5, l, 32'(102 + 3 * l));
      push(K_V, 6, l, vinit(6, l));
    end
    push(K_PC, 0, 0, 32'd0);
    repeat (3) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL midrst k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_nop_wrap();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) begin
      dut.vrf_inst.M_V_Regs[1][l] = 32'(l + 1);
      dut.vrf_inst.M_V_Regs[3][l] = 32'd5;
      dut.vrf_inst.M_V_Regs[7][l] = 32'd1000;
    end
    dut.imem_inst.memory[0] = enc(6'h3F, 3'd0, 3'd3, 3'd1, 16'hFFFF);
    dut.imem_inst.memory[1] = 32'd0;
    dut.imem_inst.memory[2] = enc(OP_VADD, 3'd7, 3'd7, 3'd1, 16'hFFFF);
    for (int l = 0; l < NUM_LANES; l++) begin
      push(K_V, 0, l, vinit(0, l));
      push(K_D, 5, l, dinit(5, l));
      push(K_V, 7, l, 32'(1001 + l));
    end
    push(K_PC, 0, 0, 32'd0);
    rst_n = 1'b0;
    repeat (64) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL nopwrap k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
    for (int l = 0; l < NUM_LANES; l++) push(K_V, 7, l, 32'(1002 + 2 * l));
    push(K_PC, 0, 0, 32'd12);
    repeat (3) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL rerun k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  task automatic test_alias();
    exp_t e; logic [31:0] got;
    setup();
    for (int l = 0; l < NUM_LANES; l++) dut.vrf_inst.M_V_Regs[1][l] = 32'd3;
    dut.imem_inst.memory[0] = enc(OP_VADD, 3'd1, 3'd1, 3'd1, 16'hFFFF);
    dut.imem_inst.memory[1] = enc(OP_VADD, 3'd1, 3'd1, 3'd1, 16'h0000);
    for (int l = 0; l < NUM_LANES; l++) push(K_V, 1, l, 32'd6);
    rst_n = 1'b0;
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL alias k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
    for (int l = 0; l < NUM_LANES; l++) push(K_V, 1, l, 32'd6);
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front(); got = obs(e.kind, e.idx, e.lane); checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL mask0 k%0d idx%0d lane%0d got %h exp %h", e.kind, e.idx, e.lane, got, e.val);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_mask();
    test_wrap();
    test_logic();
    test_mid_reset();
    test_nop_wrap();
    test_alias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_core.md
Name: gpu_core

Overview:
Single-issue, single-cycle 16-lane SIMD vector core. It contains:
- an internal instruction memory;
- an 8-entry vector register file;
- a vector-wide data memory;
- a byte-addressed program counter.

Each clock it fetches one 32-bit instruction and executes it: lane-masked vector ALU op, vector load or vector store. It has no data ports. Programs and data are preloaded by hierarchical access into the instances imem_inst, vrf_inst and dmem_inst. These instance names and their array names are mandatory.

Parameters:
NUM_LANES, 16, lanes per vector
NUM_VREGS, 8, vector registers (3-bit specifiers)
DATA_W, 32, lane width in bits
IMEM_DEPTH, 64, instruction words
DMEM_DEPTH, 64, vector-wide data words

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-high (asserted when 1); port name kept as in the codebase

Behaviour:
- Storage, all uninitialised and never cleared by reset:
  - imem_inst.memory[IMEM_DEPTH] of 32 bits.
  - vrf_inst.M_V_Regs[NUM_VREGS][NUM_LANES] of DATA_W bits.
  - dmem_inst.memory[DMEM_DEPTH][NUM_LANES] of DATA_W bits.
- Reset: only the PC is cleared, to 0, asynchronously. While reset is asserted, no register-file or memory writes occur. Contents written hierarchically during reset must survive.
- PC: byte address, 8 bits. Instruction index is PC[7:2]. PC advances by 4 every clock when not in reset. It wraps from 252 to 0. There are no branches.
- Fetch is combinational: instr = imem_inst.memory[PC[7:2]].
- Instruction fields:
  - [31:26] opcode
  - [25:23] dest
  - [22:20] src1
  - [19:17] src2
  - [16] reserved, ignored
  - [15:0] lane mask, bit i enables lane i
- Register reads are combinational: rd1 = V[src1], rd2 = V[src2], rdd = V[dest].
- Opcodes:
  - 000000 NOP: no state change.
  - 000001 VADD: V[dest][i] = rd1[i] + rd2[i], modulo 2^32.
  - 000010 VSUB: V[dest][i] = rd1[i] - rd2[i], modulo 2^32.
  - 000011 VAND, 000100 VOR, 000101 VXOR: bitwise, per lane.
  - 100000 VLOAD: V[dest][i] = DMEM[addr][i]. The DMEM read is combinational.
  - 100001 VSTORE: DMEM[addr][i] = rdd[i].
  - Any other opcode executes as NOP.
- Memory address: addr = rd1 lane 0, bits [5:0]. Upper bits are ignored, so the address wraps modulo 64. Other lanes of src1 are ignored.
- Mask: a lane with its mask bit at 0 keeps its old value. This applies to register-file lanes (ALU and VLOAD) and to DMEM lanes (VSTORE). Mask 0x0000 therefore behaves as a NOP.
- Latency: every instruction completes at the rising edge that ends its fetch cycle. The result is visible to the next instruction, so there are no hazards and no stalls.
- dest may equal src1 or src2: the old values are read and the new value is written at the edge.
- A VSTORE followed immediately by a VLOAD from the same address returns the stored data.
- Reset asserted mid-program: PC returns to 0 immediately. The write of the in-flight instruction is suppressed. Registers and memories keep their contents.

Decomposition:
- Package gpu_pkg holds:
  - the parameters above;
  - an opcode enum (OP_NOP, OP_VADD, OP_VSUB, OP_VAND, OP_VOR, OP_VXOR, OP_VLOAD, OP_VSTORE);
  - instruction field bit-position constants;
  - vector typedef logic [NUM_LANES-1:0][DATA_W-1:0].
- Sub-modules: gpu_imem (instance imem_inst), gpu_vrf (vrf_inst; three read ports, one masked write port) and gpu_dmem (dmem_inst; one combinational read, one masked write).
- Decode and the lane ALU stay inline in gpu_core.

Test Plan:
- Preload V1 lanes = 1..16, V2 = 100..115, V3 = 5 in all lanes; program VADD v0,v1,v2 mask FFFF, then VSTORE v0,[v3], then VLOAD v4,[v3], remaining words 0. Release reset and run 10 clocks. Require:
  - v0[i] = 101+2i;
  - DMEM[5][i] = v0[i];
  - v4[i] = DMEM[5][i].
- VADD with mask 0x00FF and v0 preset to 7: lanes 0-7 get the sum, lanes 8-15 stay 7. VSTORE with mask 0x8001 writes only DMEM lanes 0 and 15.
- Wrap cases:
  - V1 = FFFFFFFF, V2 = 1: VADD gives 0 in all lanes.
  - V3 lane0 = 0x45, other lanes = 9: VSTORE targets DMEM[5].
- Hold reset for 5 clocks after preloading: PC stays 0 and V/DMEM are unchanged. Assert reset after 2 instructions: PC = 0 and completed results are retained.
- Opcode 111111 and an all-zero instruction: no register or DMEM change. PC reaches 0 again after 64 clocks, so the program re-executes.
- VADD v1,v1,v1 with v1 = 3: v1 = 6 after one clock.
